pipe_scheduler: RTL and testbench
=================================

PIPE_SCHEDULER -- requirements
Module: pipe_scheduler

Interface
REQ-001 SHALL have parameter NUM_PIPES, default 3, number of pipe slots sequenced (1..8).
REQ-002 SHALL have parameter SPAWN_GAP, default 214, move ticks between successive slot enables (>=1).
REQ-003 SHALL have parameter DIV_BIT, default 19, divider bit whose rising edge produces a move tick.
REQ-004 SHALL have parameter BIRD_X, default 100, bird x coordinate used for scoring.
REQ-005 SHALL have parameter OVER_HOLD, default 48, minimum move ticks spent in OVER before restart is accepted.
REQ-006 SHALL have port clk  input  1  system clock (50 MHz).
REQ-007 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port flap  input  1  debounced user button, level.
REQ-009 SHALL have port collision  input  1  bird/pipe/ground hit, level.
REQ-010 SHALL have port pipe_x1  input  10*NUM_PIPES  packed right-edge x of each slot, slot i at [10i+9:10i].
REQ-011 SHALL have port pipe_en  output  NUM_PIPES  per-slot start/move enable, level.
REQ-012 SHALL have port pipe_rst  output  1  one-cycle reset pulse to all pipe slots.
REQ-013 SHALL have port tick  output  1  one-cycle move-tick pulse.
REQ-014 SHALL have port state  output  2  game state: 0 IDLE, 1 RUN, 2 OVER.
REQ-015 SHALL have port score  output  8  current score.
REQ-016 SHALL have port high_score  output  8  best score since reset.

Function
REQ-017 SHALL run a free 32-bit divider counter; tick high for exactly one clk when divider[DIV_BIT] goes 0->1.
REQ-018 SHALL detect flap rising edge (flap_q registered); only edges, not levels, cause transitions.
REQ-019 IDLE: pipe_en all 0, score held; flap edge -> RUN, score cleared to 0, spawn counter cleared, pipe_en[0] set same edge.
REQ-020 RUN: spawn counter increments on each tick; on reaching SPAWN_GAP-1 with next_slot < NUM_PIPES, set pipe_en[next_slot], increment next_slot, clear counter.
REQ-021 Once all slots enabled, spawn counter SHALL stop; enabled slots stay enabled until OVER.
REQ-022 RUN scoring: per slot, registered previous x1; when en and prev_x1 > BIRD_X and x1 <= BIRD_X, score +1 next cycle.
REQ-023 Simultaneous crossings of k slots in one cycle SHALL add k.
REQ-024 score SHALL saturate at 255, never wrap.
REQ-025 RUN: collision high -> OVER next cycle; collision has priority over scoring and spawning in that cycle (no increment, no spawn).
REQ-026 On entering OVER, high_score <= max(high_score, score); pipe_en all 0 (pipes freeze in place).
REQ-027 OVER: hold counter increments per tick; flap edge ignored until counter >= OVER_HOLD.
REQ-028 OVER with hold satisfied and flap edge -> IDLE, pipe_rst high exactly that one cycle, next_slot cleared to 0.
REQ-029 flap and collision in IDLE SHALL be ignored except flap edge per REQ-019.
REQ-030 state encoding 3 SHALL be unreachable; if entered, next cycle IDLE with pipe_rst pulse.

Reset
REQ-031 On reset: state=IDLE, pipe_en=0, pipe_rst=1 (held during reset), tick=0, score=0, high_score=0, divider=0, all counters and prev_x1 registers 0.
REQ-032 Reset mid-RUN or mid-OVER SHALL abandon the game immediately with REQ-031 values; high_score is also cleared.

Verification (NUM_PIPES=3, SPAWN_GAP=4, DIV_BIT=1, BIRD_X=100, OVER_HOLD=2)
REQ-033 Reset 2 cycles, release, flap pulse -> state=1, pipe_en=001 same edge; after 4 ticks 011; after 8 ticks 111; no further change.
REQ-034 RUN, drive slot1 x1 101 then 100 -> score 0->1; drive slots 0 and 2 across simultaneously -> +2; force 260 crossings -> score stays 255.
REQ-035 RUN, score=5, collision pulse coincident with crossing -> state=2, pipe_en=000, score=5, high_score=5.
REQ-036 OVER, flap edge after 1 tick -> still OVER; flap edge after 2 ticks -> state=0, pipe_rst one cycle; next flap -> score 0, high_score 5.
REQ-037 Assert reset during RUN with score=3 -> all outputs to REQ-031 values next cycle, including high_score=0.

Source files
------------

// File: rtl/pipe_scheduler.sv
// rtl/pipe_scheduler.sv - game sequencer: move tick, pipe slot spawning, scoring and IDLE/RUN/OVER flow
module pipe_scheduler #(
    parameter int NUM_PIPES = 3,
    parameter int SPAWN_GAP = 214,
    parameter int DIV_BIT   = 19,
    parameter int BIRD_X    = 100,
    parameter int OVER_HOLD = 48
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flap,
    input  logic                    collision,
    input  logic [10*NUM_PIPES-1:0] pipe_x1,
    output logic [NUM_PIPES-1:0]    pipe_en,
    output logic                    pipe_rst,
    output logic                    tick,
    output logic [1:0]              state,
    output logic [7:0]              score,
    output logic [7:0]              high_score
);
    localparam int SPAWN_W = $clog2(SPAWN_GAP + 2);
    localparam int HOLD_W  = $clog2(OVER_HOLD + 2);
    localparam int SLOT_W  = $clog2(NUM_PIPES + 2);
    localparam logic [9:0]         BIRD_X10   = 10'(BIRD_X);
    localparam logic [SPAWN_W-1:0] SPAWN_LAST = SPAWN_W'(SPAWN_GAP - 1);
    localparam logic [HOLD_W-1:0]  HOLD_MIN   = HOLD_W'(OVER_HOLD);
    localparam logic [SLOT_W-1:0]  SLOT_END   = SLOT_W'(NUM_PIPES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_OVER = 2'd2,
        S_BAD  = 2'd3
    } state_t;

    state_t                  state_q;
    logic [NUM_PIPES-1:0]    pipe_en_q;
    logic                    pipe_rst_q;
    logic                    tick_q;
    logic [7:0]              score_q;
    logic [7:0]              high_q;
    logic [31:0]             divider_q;
    logic [31:0]             divider_d;
    logic                    flap_q;
    logic [10*NUM_PIPES-1:0] prev_x1_q;
    logic [SPAWN_W-1:0]      spawn_cnt_q;
    logic [SLOT_W-1:0]       next_slot_q;
    logic [HOLD_W-1:0]       hold_cnt_q;

    logic                    flap_rise;
    logic [3:0]              cross_cnt;
    logic [8:0]              score_sum;
    logic [7:0]              score_sat;
    logic [NUM_PIPES-1:0]    next_mask;
    logic [7:0]              best_score;

    assign divider_d  = divider_q + 32'd1;
    assign flap_rise  = flap & ~flap_q;
    assign next_mask  = NUM_PIPES'(1) << next_slot_q;
    assign best_score = (score_q > high_q) ? score_q : high_q;

    // A slot scores when its right edge passes from right of the bird to at/left of it.
    always_comb begin
        cross_cnt = 4'd0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            if (pipe_en_q[i] && (prev_x1_q[10*i +: 10] > BIRD_X10) &&
                (pipe_x1[10*i +: 10] <= BIRD_X10)) begin
                cross_cnt = cross_cnt + 4'd1;
            end
        end
    end

    assign score_sum = {1'b0, score_q} + {5'b0, cross_cnt};
    assign score_sat = score_sum[8] ? 8'hFF : score_sum[7:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pipe_en_q   <= '0;
            pipe_rst_q  <= 1'b1;
            tick_q      <= 1'b0;
            score_q     <= 8'd0;
            high_q      <= 8'd0;
            divider_q   <= 32'd0;
            flap_q      <= 1'b0;
            prev_x1_q   <= '0;
            spawn_cnt_q <= '0;
            next_slot_q <= '0;
            hold_cnt_q  <= '0;
        end else begin
            divider_q  <= divider_d;
            tick_q     <= divider_d[DIV_BIT] & ~divider_q[DIV_BIT];
            flap_q     <= flap;
            prev_x1_q  <= pipe_x1;
            pipe_rst_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    pipe_en_q <= '0;
                    if (flap_rise) begin
                        state_q     <= S_RUN;
                        score_q     <= 8'd0;
                        spawn_cnt_q <= '0;
                        pipe_en_q   <= NUM_PIPES'(1);
                        next_slot_q <= SLOT_W'(1);
                    end
                end
                S_RUN: begin
                    // A hit freezes the game: no score or spawn is taken this cycle.
                    if (collision) begin
                        state_q    <= S_OVER;
                        pipe_en_q  <= '0;
                        high_q     <= best_score;
                        hold_cnt_q <= '0;
                    end else begin
                        score_q <= score_sat;
                        if (tick_q && (next_slot_q < SLOT_END)) begin
                            if (spawn_cnt_q == SPAWN_LAST) begin
                                pipe_en_q   <= pipe_en_q | next_mask;
                                next_slot_q <= next_slot_q + SLOT_W'(1);
                                spawn_cnt_q <= '0;
                            end else begin
                                spawn_cnt_q <= spawn_cnt_q + SPAWN_W'(1);
                            end
                        end
                    end
                end
                S_OVER: begin
                    pipe_en_q <= '0;
                    if (flap_rise && (hold_cnt_q >= HOLD_MIN)) begin
                        state_q     <= S_IDLE;
                        pipe_rst_q  <= 1'b1;
                        next_slot_q <= '0;
                    end else if (tick_q && (hold_cnt_q < HOLD_MIN)) begin
                        hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    pipe_rst_q  <= 1'b1;
                    pipe_en_q   <= '0;
                    next_slot_q <= '0;
                end
            endcase
        end
    end

    assign pipe_en    = pipe_en_q;
    assign pipe_rst   = pipe_rst_q;
    assign tick       = tick_q;
    assign state      = state_q;
    assign score      = score_q;
    assign high_score = high_q;
endmodule

// File: tb/tb_pipe_scheduler.sv
// tb/tb_pipe_scheduler.sv - bench for pipe_scheduler: directed sequences, scoring table, randomized lockstep model
module tb_pipe_scheduler;
    localparam int NP  = 3;
    localparam int GAP = 4;
    localparam int DB  = 1;
    localparam int BX  = 100;
    localparam int OH  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flap = 1'b0;
    logic        collision = 1'b0;
    logic [29:0] pipe_x1 = '0;
    logic [2:0]  pipe_en;
    logic        pipe_rst;
    logic        tick;
    logic [1:0]  state;
    logic [7:0]  score;
    logic [7:0]  high_score;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_scheduler #(
        .NUM_PIPES(NP), .SPAWN_GAP(GAP), .DIV_BIT(DB), .BIRD_X(BX), .OVER_HOLD(OH)
    ) dut (
        .clk(clk), .reset(reset), .flap(flap), .collision(collision),
        .pipe_x1(pipe_x1), .pipe_en(pipe_en), .pipe_rst(pipe_rst), .tick(tick),
        .state(state), .score(score), .high_score(high_score)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: game rules in plain integers, one update per clock.
    int m_state = 0, m_score = 0, m_high = 0, m_en = 0, m_next = 0;
    int m_spawn = 0, m_hold = 0, m_cycles = 0, m_tick = 0, m_rst = 1, m_flap_prev = 0;
    int m_prev[NP];

    always @(posedge clk) begin : model
        int fe, k, x;
        if (reset) begin
            m_state = 0; m_score = 0; m_high = 0; m_en = 0; m_next = 0;
            m_spawn = 0; m_hold = 0; m_cycles = 0; m_tick = 0; m_rst = 1; m_flap_prev = 0;
            for (int i = 0; i < NP; i++) m_prev[i] = 0;
        end else begin
            fe = (flap && !m_flap_prev) ? 1 : 0;
            m_rst = 0;
            if (m_state == 0) begin
                if (fe != 0) begin
                    m_state = 1; m_score = 0; m_spawn = 0; m_en = 1; m_next = 1;
                end
            end else if (m_state == 1) begin
                if (collision) begin
                    m_state = 2; m_en = 0; m_hold = 0;
                    if (m_score > m_high) m_high = m_score;
                end else begin
                    k = 0;
                    for (int i = 0; i < NP; i++) begin
                        x = int'(pipe_x1[10*i +: 10]);
                        if (((m_en >> i) & 1) == 1 && m_prev[i] > BX && x <= BX) k++;
                    end
                    m_score = (m_score + k > 255) ? 255 : m_score + k;
                    if (m_tick == 1 && m_next < NP) begin
                        if (m_spawn == GAP - 1) begin
                            m_en = m_en | (1 << m_next); m_next++; m_spawn = 0;
                        end else m_spawn++;
                    end
                end
            end else begin
                if (fe != 0 && m_hold >= OH) begin
                    m_state = 0; m_rst = 1; m_next = 0;
                end else if (m_tick == 1) m_hold++;
            end
            for (int i = 0; i < NP; i++) m_prev[i] = int'(pipe_x1[10*i +: 10]);
            m_flap_prev = flap ? 1 : 0;
            m_cycles++;
            m_tick = (m_cycles % 4 == 2) ? 1 : 0;
        end
    end

    always @(negedge clk) begin
        chk("lock_state", int'(state), m_state);
        chk("lock_pipe_en", int'(pipe_en), m_en);
        chk("lock_pipe_rst", int'(pipe_rst), m_rst);
        chk("lock_tick", int'(tick), m_tick);
        chk("lock_score", int'(score), m_score);
        chk("lock_high", int'(high_score), m_high);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Counts tick pulses seen at negedges (including the current one), then steps past the last.
    task automatic wait_ticks(input int n);
        int seen = 0;
        for (int g = 0; g < 400 && seen < n; g++) begin
            if (tick) seen++;
            if (seen < n) @(negedge clk);
        end
        if (seen < n) chk("tick_timeout", seen, n);
        @(negedge clk);
    endtask

    task automatic pulse_flap();
        flap = 1'b1;
        cyc(1);
    endtask

    typedef struct {
        logic [29:0] xa;
        logic [29:0] xb;
        int          exp_score;
    } vec_t;

    vec_t vt[5];

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        vt[0] = '{{10'd200, 10'd101, 10'd200}, {10'd200, 10'd100, 10'd200}, 1};
        vt[1] = '{{10'd200, 10'd100, 10'd200}, {10'd100, 10'd100, 10'd100}, 3};
        vt[2] = '{{10'd150, 10'd150, 10'd150}, {10'd101, 10'd101, 10'd101}, 3};
        vt[3] = '{{10'd101, 10'd101, 10'd101}, {10'd1023, 10'd101, 10'd101}, 3};
        vt[4] = '{{10'd1023, 10'd101, 10'd101}, {10'd0, 10'd101, 10'd100}, 5};

        reset = 1'b1;
        cyc(2);
        chk("rst_state", int'(state), 0);
        chk("rst_pipe_en", int'(pipe_en), 0);
        chk("rst_pipe_rst", int'(pipe_rst), 1);
        chk("rst_tick", int'(tick), 0);
        chk("rst_score", int'(score), 0);
        chk("rst_high", int'(high_score), 0);
        reset = 1'b0;
        cyc(1);
        chk("release_pipe_rst", int'(pipe_rst), 0);

        collision = 1'b1;
        cyc(3);
        chk("idle_ignores_collision", int'(state), 0);
        collision = 1'b0;

        pipe_x1 = {10'd200, 10'd200, 10'd200};
        cyc(1);
        pulse_flap();
        chk("start_state", int'(state), 1);
        chk("start_pipe_en", int'(pipe_en), 3'b001);
        flap = 1'b0;
        wait_ticks(GAP);
        chk("spawn_second", int'(pipe_en), 3'b011);
        wait_ticks(GAP);
        chk("spawn_third", int'(pipe_en), 3'b111);
        wait_ticks(2 * GAP);
        chk("spawn_stopped", int'(pipe_en), 3'b111);

        for (int r = 0; r < 5; r++) begin
            pipe_x1 = vt[r].xa;
            cyc(1);
            pipe_x1 = vt[r].xb;
            cyc(1);
            chk($sformatf("score_row%0d", r), int'(score), vt[r].exp_score);
        end

        pipe_x1 = {10'd0, 10'd100, 10'd100};
        collision = 1'b1;
        cyc(1);
        collision = 1'b0;
        chk("hit_state", int'(state), 2);
        chk("hit_pipe_en", int'(pipe_en), 0);
        chk("hit_score", int'(score), 5);
        chk("hit_high", int'(high_score), 5);

        wait_ticks(1);
        pulse_flap();
        chk("over_hold_early", int'(state), 2);
        flap = 1'b0;
        cyc(1);
        wait_ticks(1);
        pulse_flap();
        chk("over_exit_state", int'(state), 0);
        chk("over_exit_rst", int'(pipe_rst), 1);
        flap = 1'b0;
        cyc(1);
        chk("over_exit_rst_once", int'(pipe_rst), 0);
        chk("idle_score_held", int'(score), 5);
        pulse_flap();
        chk("restart_score", int'(score), 0);
        chk("restart_high", int'(high_score), 5);
        chk("restart_pipe_en", int'(pipe_en), 3'b001);
        flap = 1'b0;

        pipe_x1 = '0;
        cyc(1);
        for (int i = 0; i < 260; i++) begin
            pipe_x1[9:0] = 10'd101;
            cyc(1);
            pipe_x1[9:0] = 10'd100;
            cyc(1);
            if (i == 199) chk("score_mid", int'(score), 200);
        end
        chk("score_saturated", int'(score), 255);
        collision = 1'b1;
        cyc(1);
        collision = 1'b0;
        chk("sat_high", int'(high_score), 255);

        wait_ticks(OH);
        pulse_flap();
        flap = 1'b0;
        cyc(1);
        pulse_flap();
        flap = 1'b0;
        chk("game3_state", int'(state), 1);
        for (int i = 0; i < 3; i++) begin
            pipe_x1[9:0] = 10'd101;
            cyc(1);
            pipe_x1[9:0] = 10'd100;
            cyc(1);
        end
        chk("game3_score", int'(score), 3);
        reset = 1'b1;
        cyc(1);
        chk("midrun_rst_state", int'(state), 0);
        chk("midrun_rst_pipe_en", int'(pipe_en), 0);
        chk("midrun_rst_pipe_rst", int'(pipe_rst), 1);
        chk("midrun_rst_tick", int'(tick), 0);
        chk("midrun_rst_score", int'(score), 0);
        chk("midrun_rst_high", int'(high_score), 0);
        reset = 1'b0;

        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 7) == 0) flap = ~flap;
            collision = ($urandom_range(0, 199) == 0);
            for (int s = 0; s < NP; s++) begin
                if ($urandom_range(0, 9) < 2) pipe_x1[10*s +: 10] = 10'($urandom_range(0, 1023));
                else pipe_x1[10*s +: 10] = 10'($urandom_range(97, 104));
            end
            cyc(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
